// File: rtl/id_ex_pipe_reg_pkg.sv
// ============================================================================
// Module  : id_ex_pipe_reg_pkg
// Brief   : Shared widths, control encodings and the control-bundle type
//           for the ID/EX pipeline register.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package id_ex_pipe_reg_pkg;

  // Default datapath geometry
  localparam int c_xlen_def   = 32;
  localparam int c_reg_aw_def = 5;
  localparam int c_cnt_w_def  = 16;

  // Control field widths
  localparam int c_wd_sel_w = 3;
  localparam int c_alu_op_w = 5;
  localparam int c_npc_op_w = 3;

  // Write-back data select encodings
  localparam logic [c_wd_sel_w-1:0] c_wd_alu = 3'd0;
  localparam logic [c_wd_sel_w-1:0] c_wd_mem = 3'd1;
  localparam logic [c_wd_sel_w-1:0] c_wd_pc4 = 3'd2;
  localparam logic [c_wd_sel_w-1:0] c_wd_imm = 3'd3;

  // ALU operation encodings
  localparam logic [c_alu_op_w-1:0] c_alu_add  = 5'h00;
  localparam logic [c_alu_op_w-1:0] c_alu_sub  = 5'h01;
  localparam logic [c_alu_op_w-1:0] c_alu_and  = 5'h02;
  localparam logic [c_alu_op_w-1:0] c_alu_or   = 5'h03;
  localparam logic [c_alu_op_w-1:0] c_alu_xor  = 5'h04;
  localparam logic [c_alu_op_w-1:0] c_alu_sll  = 5'h05;
  localparam logic [c_alu_op_w-1:0] c_alu_srl  = 5'h06;
  localparam logic [c_alu_op_w-1:0] c_alu_sra  = 5'h07;
  localparam logic [c_alu_op_w-1:0] c_alu_slt  = 5'h08;
  localparam logic [c_alu_op_w-1:0] c_alu_sltu = 5'h09;

  // Next-PC operation encodings
  localparam logic [c_npc_op_w-1:0] c_npc_pc4  = 3'd0;
  localparam logic [c_npc_op_w-1:0] c_npc_br   = 3'd1;
  localparam logic [c_npc_op_w-1:0] c_npc_jal  = 3'd2;
  localparam logic [c_npc_op_w-1:0] c_npc_jalr = 3'd3;

  // Decoded control bundle; field order is the packing order used by the top
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic [c_wd_sel_w-1:0] wd_sel;
    logic                  alu_src;
    logic [c_alu_op_w-1:0] alu_op;
    logic [c_npc_op_w-1:0] npc_op;
  } ctrl_t;

  localparam int    c_ctrl_w   = $bits(ctrl_t);
  // A bubble carries all-zero control: no register write, no memory write
  localparam ctrl_t c_ctrl_nop = '0;

  // Control survives only alongside a real instruction
  function automatic ctrl_t gate_ctrl(input logic valid, input ctrl_t ctrl);
    return valid ? ctrl : c_ctrl_nop;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_pipe_reg_field.sv
// ============================================================================
// Module  : id_ex_pipe_reg_field
// Brief   : Generic W-bit pipeline field register. Async active-low reset,
//           synchronous clear (highest priority) and hold.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_pipe_reg_field #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Clear beats hold so a flush always lands even while the stage is stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (!hold) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// Module  : id_ex_pipe_reg
// Brief   : ID/EX pipeline register with stall (hold), flush (bubble),
//           valid tracking and a saturating bubble counter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int XLEN   = c_xlen_def,
  parameter int REG_AW = c_reg_aw_def,
  parameter int CNT_W  = c_cnt_w_def
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  cnt_clr,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_mem_write,
  input  logic [c_wd_sel_w-1:0] id_wd_sel,
  input  logic                  id_alu_src,
  input  logic [c_alu_op_w-1:0] id_alu_op,
  input  logic [c_npc_op_w-1:0] id_npc_op,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rd1,
  input  logic [XLEN-1:0]       id_rd2,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic [REG_AW-1:0]     id_rd,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_write,
  output logic [c_wd_sel_w-1:0] ex_wd_sel,
  output logic                  ex_alu_src,
  output logic [c_alu_op_w-1:0] ex_alu_op,
  output logic [c_npc_op_w-1:0] ex_npc_op,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rd1,
  output logic [XLEN-1:0]       ex_rd2,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_AW-1:0]     ex_rs1,
  output logic [REG_AW-1:0]     ex_rs2,
  output logic [REG_AW-1:0]     ex_rd,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int               c_data_w  = 4 * XLEN + 3 * REG_AW;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t               w_id_ctrl;
  ctrl_t               w_ctrl_d;
  ctrl_t               w_ex_ctrl;
  logic [c_data_w-1:0] w_data_d;
  logic [c_data_w-1:0] w_data_q;
  logic                w_valid_q;
  logic                w_bubble;
  logic                w_cnt_sat;
  logic [CNT_W-1:0]    r_bubble_cnt;

  // The upstream bubble mux already zeroes control for invalid slots; gating
  // again here means a bubble can never write even if that mux misbehaves.
  assign w_id_ctrl = {id_reg_write, id_mem_write, id_wd_sel,
                      id_alu_src, id_alu_op, id_npc_op};
  assign w_ctrl_d  = gate_ctrl(id_valid, w_id_ctrl);
  assign w_data_d  = {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd};

  id_ex_pipe_reg_field #(.W(c_ctrl_w)) u_ctrl (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .hold (stall),
    .d    (w_ctrl_d),
    .q    (w_ex_ctrl)
  );

  id_ex_pipe_reg_field #(.W(c_data_w)) u_data (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .hold (stall),
    .d    (w_data_d),
    .q    (w_data_q)
  );

  id_ex_pipe_reg_field #(.W(1)) u_valid (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .hold (stall),
    .d    (id_valid),
    .q    (w_valid_q)
  );

  assign ex_valid     = w_valid_q;
  assign ex_reg_write = w_ex_ctrl.reg_write;
  assign ex_mem_write = w_ex_ctrl.mem_write;
  assign ex_wd_sel    = w_ex_ctrl.wd_sel;
  assign ex_alu_src   = w_ex_ctrl.alu_src;
  assign ex_alu_op    = w_ex_ctrl.alu_op;
  assign ex_npc_op    = w_ex_ctrl.npc_op;
  assign {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd} = w_data_q;

  // A bubble enters EX on a flush, or on a load of an empty ID slot; a plain
  // stall only freezes the slot and is not counted.
  assign w_bubble  = flush | (~stall & ~id_valid);
  assign w_cnt_sat = &r_bubble_cnt;

  // Saturating bubble counter; a same-edge clear wins over the increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && !w_cnt_sat) begin
      r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire
